// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the shared multiplier / iterative divider used by EX.
// Accepts one mult/multu/div/divu at a time, stalls EX until the result is ready, then writes HI/LO once.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_sel,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_start,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_e;

  localparam logic [2:0] LAT = 3'(MUL_LAT);

  state_e      state_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [2:0]  cnt_q;
  logic [63:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && !flush) begin
            a_q   <= src1;
            b_q   <= src2;
            op_q  <= op_sel;
            cnt_q <= 3'd1;
            if (!op_sel[1]) begin
              state_q <= MUL_WAIT;
            end else if (src2 == '0) begin
              // Divide by zero: the divider is bypassed and the fixed result goes straight to DONE.
              res_q   <= {src1, 32'hFFFF_FFFF};
              state_q <= DONE;
            end else begin
              state_q <= DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            res_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == LAT) begin
            res_q   <= mul_result;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DIV_WAIT: begin
          if (flush) begin
            res_q   <= '0;
            state_q <= IDLE;
          end else if (div_ready) begin
            res_q   <= div_result;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (flush || !pipe_hold) begin
            res_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq    = 1'b0;
    busy        = (state_q != IDLE);
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    div_start   = 1'b0;
    div_annul   = 1'b0;
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;
    case (state_q)
      IDLE: stallreq = op_valid && !flush && !rst;
      MUL_WAIT: begin
        stallreq   = !flush && !rst;
        mul_signed = (op_q == 2'b00);
        mul_ina    = a_q;
        mul_inb    = b_q;
      end
      DIV_WAIT: begin
        stallreq    = !flush && !rst;
        div_signed  = (op_q == 2'b10);
        div_opdata1 = a_q;
        div_opdata2 = b_q;
        div_start   = !div_ready && !flush && !rst;
        // Reset clears the divider directly, so annul is only raised for a real flush.
        div_annul   = flush && !rst;
      end
      DONE: begin
        hilo_we  = !pipe_hold && !flush && !rst;
        hi_wdata = res_q[63:32];
        lo_wdata = res_q[31:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl with behavioural multiplier/divider models and a HI/LO write scoreboard.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned MIDX = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush, pipe_hold;
  logic [1:0]  op_sel;
  logic [31:0] src1, src2;
  logic        stallreq, busy, mul_signed, div_signed, div_start, div_annul, div_ready, hilo_we;
  logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2, hi_wdata, lo_wdata;
  logic [63:0] mul_result, div_result;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [63:0] sb[$];

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel), .src1(src1), .src2(src2),
    .flush(flush), .pipe_hold(pipe_hold), .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_signed(div_signed), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_start(div_start), .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  // Multiplier model: result visible in the MUL_LAT-th cycle of operand presentation.
  logic [63:0] prod;
  logic [63:0] mstage [0:6];
  always_comb begin
    if (mul_signed) prod = {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
    else            prod = {32'h0, mul_ina} * {32'h0, mul_inb};
  end
  always_ff @(posedge clk) begin
    mstage[0] <= prod;
    for (int i = 1; i < 7; i++) mstage[i] <= mstage[i-1];
  end
  assign mul_result = (MUL_LAT == 1) ? prod : mstage[MIDX];

  // Divider model: ready after 33 cycles of div_start.
  logic [5:0] dcnt_q;
  assign div_ready = (dcnt_q == 6'd33);
  always_ff @(posedge clk) begin
    if (rst || div_annul || div_ready) dcnt_q <= '0;
    else if (div_start)                dcnt_q <= dcnt_q + 6'd1;
  end
  always_comb begin
    div_result = '0;
    if (div_opdata2 != 0) begin
      if (div_signed)
        div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                      32'($signed(div_opdata1) / $signed(div_opdata2))};
      else
        div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every HI/LO write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      if (sb.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_hilo_we: got write %h_%h expected no write", hi_wdata, lo_wdata);
      end else begin
        chk("hilo_write", {hi_wdata, lo_wdata}, sb.pop_front());
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int exp_stall, input int exp_start,
                        input logic [63:0] exp_res);
    int n_stall = 0;
    int n_start = 0;
    sb.push_back(exp_res);
    op_valid = 1'b1; op_sel = sel; src1 = a; src2 = b; pipe_hold = (hold > 0);
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (!stallreq) break;
      n_stall++;
      if (div_start) n_start++;
      next_cyc();
    end
    chk("stall_cycles", 64'(n_stall), 64'(exp_stall));
    chk("div_start_cycles", 64'(n_start), 64'(exp_start));
    chk("done_busy", 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_no_we", 64'(hilo_we), 64'd0);
      chk("hold_stable", {hi_wdata, lo_wdata}, exp_res);
      next_cyc();
      if (i == hold - 1) pipe_hold = 1'b0;
      @(negedge clk);
    end
    chk("done_we", 64'(hilo_we), 64'd1);
    next_cyc();
    op_valid = 1'b0; src1 = '0; src2 = '0;
    @(negedge clk);
    chk("back_idle", {62'd0, busy, hilo_we}, 64'd0);
    next_cyc();
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_sel = '0; src1 = '0; src2 = '0; flush = 1'b0; pipe_hold = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {57'd0, stallreq, busy, hilo_we, div_start, div_annul, mul_signed, div_signed}, 64'd0);
    chk("reset_data", {32'd0, mul_ina | mul_inb | div_opdata1 | div_opdata2 | hi_wdata | lo_wdata}, 64'd0);
    next_cyc();

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 3, 0, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 3, 0, 64'h0000_0001_FFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 3, 3, 0, 64'h0000_0001_FFFF_FFFE);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 35, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd2, 0, 35, 33, 64'h0000_0001_0000_0003);
    run_op(2'b10, 32'd1234, 32'd0, 0, 1, 0, {32'd1234, 32'hFFFF_FFFF});

    // Flush in the 10th DIV_WAIT cycle.
    op_valid = 1'b1; op_sel = 2'b10; src1 = 32'd100; src2 = 32'd3;
    for (int i = 0; i < 10; i++) next_cyc();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_div_annul", 64'(div_annul), 64'd1);
    chk("flush_div_stall", {62'd0, stallreq, hilo_we}, 64'd0);
    next_cyc();
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_div_after", {61'd0, div_annul, busy, div_start}, 64'd0);
    next_cyc();

    // Flush coinciding with div_ready.
    op_valid = 1'b1; op_sel = 2'b11; src1 = 32'd50; src2 = 32'd5;
    for (int g = 0; g < 100; g++) begin
      next_cyc();
      if (div_ready) break;
    end
    chk("ready_seen", 64'(div_ready), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy_annul", 64'(div_annul), 64'd1);
    chk("flush_rdy_stall", {62'd0, stallreq, hilo_we}, 64'd0);
    next_cyc();
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_rdy_after", {61'd0, div_annul, busy, hilo_we}, 64'd0);
    next_cyc();

    // Flush in the acceptance cycle.
    op_valid = 1'b1; op_sel = 2'b00; src1 = 32'd3; src2 = 32'd4; flush = 1'b1;
    @(negedge clk);
    chk("flush_acc_stall", 64'(stallreq), 64'd0);
    next_cyc();
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_acc_idle", {62'd0, busy, mul_signed}, 64'd0);
    chk("flush_acc_ops", {mul_ina, mul_inb}, 64'd0);
    next_cyc();

    // Reset during DIV_WAIT.
    op_valid = 1'b1; op_sel = 2'b10; src1 = 32'd9; src2 = 32'd4;
    for (int i = 0; i < 5; i++) next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {61'd0, div_annul, hilo_we, stallreq}, 64'd0);
    next_cyc();
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {61'd0, busy, div_start, hilo_we}, 64'd0);
    next_cyc();

    // A following operation still completes normally.
    run_op(2'b00, 32'd6, 32'd7, 0, 3, 0, 64'd42);

    next_cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the shared multiply and divide units used by the EX stage of the 5-stage MIPS core. It accepts one mult/multu/div/divu operation at a time from EX and registers its operands. It drives the pipelined multiplier or the iterative divider, and holds EX stalled until the result is available. It then issues a single HI/LO write. It also handles flush (annul), divide-by-zero and downstream pipeline hold.

## Interface
Parameters:
- MUL_LAT, 2, cycles from multiplier operand presentation to valid `mul_result` (1..7).

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  EX holds a mul/div instruction (level, held while stalled)
- op_sel  in  2  00 mult, 01 multu, 10 div, 11 divu
- src1, src2  in  32 each  rs / rt operand values
- flush  in  1  annul in-flight operation
- pipe_hold  in  1  EX cannot advance this cycle due to a downstream stall
- stallreq  out  1  stall request to the stall controller (combinational)
- busy  out  1  FSM not in IDLE
- mul_signed  out  1  signed multiply select
- mul_ina, mul_inb  out  32 each  multiplier operands
- mul_result  in  64  {hi, lo} product
- div_signed  out  1  signed divide select
- div_opdata1, div_opdata2  out  32 each  dividend, divisor
- div_start  out  1  divider start level
- div_annul  out  1  divider abort pulse
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid
- hilo_we  out  1  HI/LO write strobe
- hi_wdata, lo_wdata  out  32 each  HI/LO write data

## Operation
- The FSM has four states: IDLE, MUL_WAIT, DIV_WAIT, DONE. Registers hold the operands (a, b), the op type, a 3-bit latency counter, and the 64-bit result.
- IDLE with op_valid=1 and flush=0 accepts the operation:
  - Latch src1/src2/op_sel.
  - `stallreq`=1 combinationally in that same cycle.
  - Next state is MUL_WAIT for op_sel[1]=0, or DIV_WAIT for op_sel[1]=1.
  - Exception: div/divu with src2==0 goes directly to DONE with result HI=src1, LO=32'hFFFF_FFFF, and the divider is never started.
- MUL_WAIT:
  - Drive `mul_ina/inb` from the latched operands and `mul_signed`=(op==mult). The counter counts 1..MUL_LAT.
  - In the cycle the counter equals MUL_LAT, capture `mul_result` and go to DONE.
  - `stallreq`=1 throughout.
- DIV_WAIT:
  - Drive `div_opdata1/2` from the latched operands and `div_signed`=(op==div).
  - `div_start`=1 while div_ready=0.
  - When div_ready=1: `div_start`=0 that cycle, capture `div_result` ({HI=remainder, LO=quotient}), go to DONE.
  - `stallreq`=1 throughout. No timeout.
- DONE:
  - `stallreq`=0, `hi_wdata/lo_wdata` = captured result.
  - If pipe_hold=0: `hilo_we`=1 for this cycle and the next state is IDLE.
  - If pipe_hold=1: `hilo_we`=0, stay in DONE, result held stable.
  - op_valid is ignored in DONE, so the same instruction is never re-accepted.
- Operand outputs to both units are 0 whenever the unit is not being driven.
- Flush in any non-IDLE state, or together with acceptance:
  - Next state is IDLE and the captured result is discarded; `hilo_we` is never asserted for the annulled operation.
  - `div_annul`=1 for exactly one cycle if flush arrives in DIV_WAIT.
  - `stallreq`=0 in the flush cycle.
- Flush has priority over pipe_hold and div_ready arriving in the same cycle.
- rst has priority over everything:
  - next state IDLE, all registers cleared;
  - reset values of every output: stallreq=0, busy=0, hilo_we=0, div_start=0, div_annul=0, all data outputs 0.
  - Reset mid-operation does not pulse div_annul; the divider shares rst.

## Timing
- Multiply, acceptance in cycle T:
  - T..T+MUL_LAT: stallreq=1.
  - T+MUL_LAT+1: DONE, hilo_we=1 if no hold. EX is held for MUL_LAT+1 cycles.
- Divide, acceptance in cycle T:
  - div_start rises at T+1.
  - div_ready sampled in cycle R gives DONE at R+1.
  - stallreq=1 from T through R.
- Divide by zero: accept at T, DONE at T+1.
- Back-to-back operations: the earliest next acceptance is the cycle after DONE/hilo_we. There is no bubble beyond the IDLE re-entry.
- busy=1 in MUL_WAIT, DIV_WAIT and DONE.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required response: every output 0, busy=0.
  - Stimulus: a 1-cycle rst during DIV_WAIT.
  - Required response: IDLE next cycle, no hilo_we.
- mult, src1=32'hFFFF_FFFD, src2=5, MUL_LAT=2 -> stallreq high 3 cycles, then hilo_we=1 once with HI=FFFF_FFFF, LO=FFFF_FFF1.
- multu:
  - Stimulus: src1=FFFF_FFFF, src2=2.
  - Required response: HI=0000_0001, LO=FFFF_FFFE.
  - Same operation with pipe_hold=1 for 3 DONE cycles: hilo_we stays 0 and the result is stable; hilo_we pulses exactly once on release.
- div:
  - Stimulus: src1=-7, src2=2, divider model ready after 33 cycles.
  - Required response: div_start high 33 cycles, then DONE with HI=FFFF_FFFF, LO=FFFF_FFFD.
  - Same setup with divu: src1=7, src2=2 -> HI=1, LO=3.
- Divide by zero: div with src2=0, src1=1234 -> div_start never asserted; DONE at T+1 with HI=1234, LO=FFFF_FFFF.
- Flush:
  - Flush asserted in the 10th DIV_WAIT cycle -> div_annul 1-cycle pulse, IDLE next cycle, no hilo_we.
  - Flush coinciding with div_ready -> same result.
  - Flush in the acceptance cycle -> stays IDLE.
